// File: rtl/led_pwm_dimmer_if.sv
// Avalon-MM register port for the LED PWM dimmer.
// Master drives address/strobes/writedata; slave returns readdata.
interface led_pwm_dimmer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, read, write, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read, write, writedata,
        output readdata
    );
endinterface

// File: rtl/led_pwm_dimmer.sv
// LED PWM dimmer: global brightness, blink envelope and polarity
// applied to the 10-bit LED pattern, configured over Avalon-MM.
module led_pwm_dimmer #(
    parameter int PWM_BITS = 8,
    parameter int PRE_W    = 16,
    parameter int BLINK_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    led_pwm_dimmer_if.slave        bus,
    input  logic [9:0]             led_in,
    output logic [9:0]             led_pwm_out
);

    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

    logic                wr, rd;
    logic                ctrl_wr;
    logic                enable, blink_en, invert;
    logic [PWM_BITS-1:0] duty, duty_act;
    logic [PRE_W-1:0]    prescale, pre_cnt;
    logic [BLINK_W-1:0]  blink, blink_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                blink_phase;
    logic                tick, wrap, clr, blink_clr;
    logic                pwm_on, gate;
    logic [31:0]         rd_val;
    logic                unused_wdata;

    assign wr      = bus.chipselect & bus.write;
    assign rd      = bus.chipselect & bus.read & ~bus.write;
    assign ctrl_wr = wr && (bus.address == 2'd0);

    // Counters clear on the same edge a CTRL write drops enable,
    // so a coincident period wrap cannot leave them non-zero.
    assign clr       = ~enable | (ctrl_wr & ~bus.writedata[0]);
    assign blink_clr = clr | ~blink_en;

    assign tick   = (pre_cnt >= prescale);
    assign wrap   = tick && (pwm_cnt == PWM_MAX);
    assign pwm_on = (pwm_cnt < duty_act);
    assign gate   = enable & pwm_on & blink_phase;

    assign unused_wdata = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable   <= 1'b0;
            blink_en <= 1'b0;
            invert   <= 1'b0;
            duty     <= '0;
            prescale <= '0;
            blink    <= '0;
        end else if (wr) begin
            case (bus.address)
                2'd0: begin
                    enable   <= bus.writedata[0];
                    blink_en <= bus.writedata[1];
                    invert   <= bus.writedata[2];
                end
                2'd1: duty     <= bus.writedata[PWM_BITS-1:0];
                2'd2: prescale <= bus.writedata[PRE_W-1:0];
                2'd3: blink    <= bus.writedata[BLINK_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        case (bus.address)
            2'd0: rd_val[2:0] = {invert, blink_en, enable};
            2'd1: rd_val[PWM_BITS-1:0] = duty;
            2'd2: rd_val[PRE_W-1:0] = prescale;
            2'd3: begin
                rd_val[BLINK_W-1:0] = blink;
                rd_val[31]          = blink_phase;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd ? rd_val : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else if (clr) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            pwm_cnt <= pwm_cnt + 1'b1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Software DUTY only reaches the comparator between periods.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_act <= '0;
        end else if (!enable || wrap) begin
            duty_act <= duty;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_clr) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (wrap) begin
            if (blink_cnt >= blink) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_pwm_out <= '0;
        end else begin
            led_pwm_out <= (gate ? led_in : 10'b0) ^ {10{invert}};
        end
    end

endmodule
